sr_ff_checker: RTL and testbench

Synthesizable in-line checker for the SR flip-flop. It is the observing end of the S/R interface: it samples the same `S`, `R` and `Q` nets the flip-flop sees and runs a cycle-accurate reference model of the flip-flop. It counts mismatches and illegal `S=R=1` requests, and reports a pass/fail verdict. It sits beside an `SR_FF` instance, in a bench or on an FPGA self-test harness, and is clocked from the same clock.

---
 rtl/sr_chk_pkg.sv | 17 +
 rtl/sr_ref_next.sv | 30 +++
 rtl/sr_ff_checker.sv | 136 +++++++++++++
 tb/tb_sr_ff_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_chk_pkg.sv
// Shared types for the SR flip-flop in-line checker: checker states and S/R pair encodings.
package sr_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // {S,R} pair encodings as seen on the flip-flop inputs
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] ILL  = 2'b11;

endpackage

// File: rtl/sr_ref_next.sv
// Combinational next-state function of an ideal SR flip-flop.
// On the illegal S=R=1 pair the output value is meaningless, so the current
// value is passed through and 'ill' tells the caller to distrust it.
module sr_ref_next
   import sr_chk_pkg::*;
(
   input  logic q,
   input  logic s,
   input  logic r,
   output logic q_next,
   output logic ill
);

   // Map the S/R pair onto the next flip-flop value
   always_comb begin
      q_next = q;
      ill    = 1'b0;
      case ({s, r})
         HOLD: q_next = q;
         RST:  q_next = 1'b0;
         SET:  q_next = 1'b1;
         ILL: begin
            q_next = q;
            ill    = 1'b1;
         end
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/sr_ff_checker.sv
// In-line checker for an SR flip-flop: tracks the expected Q from the tapped
// S/R inputs, compares it against the tapped Q one cycle later, and keeps
// saturating mismatch / illegal-input / cycle counters plus a pass/fail verdict.
module sr_ff_checker
   import sr_chk_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             s_in,
   input  logic             r_in,
   input  logic             q_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [CYC_W-1:0] cyc_cnt,
   output logic [CYC_W-1:0] first_err_cyc
);

   state_e           state_q, state_d;
   logic             expQ_q, expValid_q;
   logic             firstSeen_q;
   logic             errPulse_q;
   logic             busy_q, done_q, pass_q, fail_q;
   logic [CNT_W-1:0] errCnt_q, errCnt_d;
   logic [CNT_W-1:0] illCnt_q;
   logic [CYC_W-1:0] cycCnt_q;
   logic [CYC_W-1:0] firstErr_q;

   logic refQ, refNext, refIll, mismatch;

   // ARM seeds the model from the real Q; RUN advances the model's own copy
   assign refQ     = (state_q == RUN) ? expQ_q : q_in;
   assign mismatch = (state_q == RUN) && expValid_q && (q_in != expQ_q);

   sr_ref_next uRef (
      .q      (refQ),
      .s      (s_in),
      .r      (r_in),
      .q_next (refNext),
      .ill    (refIll)
   );

   // Next checker state from the start/stop pulses; start wins over stop in DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ARM;
         ARM:     state_d = RUN;
         RUN:     if (stop) state_d = DONE;
         DONE:    if (start) state_d = ARM;
         default: state_d = IDLE;
      endcase
   end

   // Next mismatch count, needed early so the verdict can be registered with it
   always_comb begin
      errCnt_d = errCnt_q;
      if (state_q == ARM) begin
         errCnt_d = '0;
      end else if (mismatch && !(&errCnt_q)) begin
         errCnt_d = errCnt_q + CNT_W'(1);
      end
   end

   // State, reference model, counters and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         expQ_q      <= 1'b0;
         expValid_q  <= 1'b0;
         firstSeen_q <= 1'b0;
         errPulse_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         errCnt_q    <= '0;
         illCnt_q    <= '0;
         cycCnt_q    <= '0;
         firstErr_q  <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d == ARM) || (state_d == RUN);
         done_q     <= (state_d == DONE);
         pass_q     <= (state_d == DONE) && (errCnt_d == '0);
         fail_q     <= (state_d == DONE) && (errCnt_d != '0);
         errPulse_q <= mismatch;
         errCnt_q   <= errCnt_d;
         case (state_q)
            ARM: begin
               illCnt_q    <= '0;
               cycCnt_q    <= '0;
               firstErr_q  <= '0;
               firstSeen_q <= 1'b0;
               expQ_q      <= refNext;
               expValid_q  <= !refIll;
            end
            RUN: begin
               if (mismatch && !firstSeen_q) begin
                  firstErr_q  <= cycCnt_q;
                  firstSeen_q <= 1'b1;
               end
               expQ_q <= refNext;
               if (refIll) begin
                  expValid_q <= 1'b0;
                  if (!(&illCnt_q)) illCnt_q <= illCnt_q + CNT_W'(1);
               end else if (s_in ^ r_in) begin
                  expValid_q <= 1'b1;
               end
               if (!(&cycCnt_q)) cycCnt_q <= cycCnt_q + CYC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign err_pulse     = errPulse_q;
   assign err_cnt       = errCnt_q;
   assign illegal_cnt   = illCnt_q;
   assign cyc_cnt       = cycCnt_q;
   assign first_err_cyc = firstErr_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: a default-width instance and a narrow instance
// (3-bit error counters, 4-bit cycle counter) share the same stimulus.
// Expected outputs come from a run-level model that remembers the most recent
// decisive S/R command and keeps unbounded counts clamped on comparison.
module tb_sr_ff_checker;

   logic clk = 1'b0;
   logic rst = 1'b0, start = 1'b0, stop = 1'b0;
   logic sIn = 1'b0, rIn = 1'b0, qIn = 1'b0;

   logic        busy, done, pass, fail, errPulse;
   logic [7:0]  errCnt, illCnt;
   logic [15:0] cycCnt, firstErr;

   logic        busy2, done2, pass2, fail2, errPulse2;
   logic [2:0]  errCnt2, illCnt2;
   logic [3:0]  cycCnt2, firstErr2;

   int nVec = 0;
   int nMis = 0;

   // model state: phase 0 idle, 1 arm, 2 run, 3 done; mPred -1 means unknown
   int mPhase = 0, mErr = 0, mIll = 0, mCyc = 0, mFirst = 0, mPred = -1;
   bit mHadErr = 0, mPulse = 0;
   bit ffQ = 0;
   int pulses;

   typedef struct {
      bit start, stop, s, r, q;
      bit eBusy, eDone, eFail, ePulse;
      int eErr;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   sr_ff_checker #(.CNT_W(8), .CYC_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .s_in(sIn), .r_in(rIn), .q_in(qIn),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .err_pulse(errPulse),
      .err_cnt(errCnt), .illegal_cnt(illCnt), .cyc_cnt(cycCnt), .first_err_cyc(firstErr)
   );

   sr_ff_checker #(.CNT_W(3), .CYC_W(4)) dutNarrow (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .s_in(sIn), .r_in(rIn), .q_in(qIn),
      .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .err_pulse(errPulse2),
      .err_cnt(errCnt2), .illegal_cnt(illCnt2), .cyc_cnt(cycCnt2), .first_err_cyc(firstErr2)
   );

   function automatic int sat(input int v, input int maxV);
      return (v > maxV) ? maxV : v;
   endfunction

   function automatic bit ffNext(input bit q, input bit s, input bit r);
      if (s && r) return bit'($urandom_range(1, 0));
      if (s) return 1'b1;
      if (r) return 1'b0;
      return q;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nMis++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Advance the model by one clock edge using the values the DUT just sampled
   task automatic modelStep();
      if (!rst) begin
         mPhase = 0; mErr = 0; mIll = 0; mCyc = 0; mFirst = 0;
         mHadErr = 0; mPulse = 0; mPred = -1;
      end else begin
         mPulse = 0;
         case (mPhase)
            0: if (start) mPhase = 1;
            1: begin
               mErr = 0; mIll = 0; mCyc = 0; mFirst = 0; mHadErr = 0;
               if (sIn && rIn) mPred = -1;
               else if (sIn)   mPred = 1;
               else if (rIn)   mPred = 0;
               else            mPred = int'(qIn);
               mPhase = 2;
            end
            2: begin
               if (mPred >= 0 && int'(qIn) != mPred) begin
                  mErr++;
                  mPulse = 1;
                  if (!mHadErr) begin
                     mFirst = mCyc;
                     mHadErr = 1;
                  end
               end
               if (sIn && rIn) begin
                  mIll++;
                  mPred = -1;
               end else if (sIn) mPred = 1;
               else if (rIn)     mPred = 0;
               mCyc++;
               if (stop) mPhase = 3;
            end
            default: if (start) mPhase = 1;
         endcase
      end
   endtask

   task automatic checkOutput();
      bit eDone;
      eDone = (mPhase == 3);
      chk("busy",        int'(busy),     int'(mPhase == 1 || mPhase == 2));
      chk("done",        int'(done),     int'(eDone));
      chk("pass",        int'(pass),     int'(eDone && mErr == 0));
      chk("fail",        int'(fail),     int'(eDone && mErr != 0));
      chk("err_pulse",   int'(errPulse), int'(mPulse));
      chk("err_cnt",     int'(errCnt),   sat(mErr, 255));
      chk("illegal_cnt", int'(illCnt),   sat(mIll, 255));
      chk("cyc_cnt",     int'(cycCnt),   sat(mCyc, 65535));
      chk("first_err",   int'(firstErr), sat(mFirst, 65535));
      chk("n_pass",      int'(pass2),    int'(eDone && mErr == 0));
      chk("n_err_pulse", int'(errPulse2), int'(mPulse));
      chk("n_err_cnt",   int'(errCnt2),  sat(mErr, 7));
      chk("n_ill_cnt",   int'(illCnt2),  sat(mIll, 7));
      chk("n_cyc_cnt",   int'(cycCnt2),  sat(mCyc, 15));
      chk("n_first_err", int'(firstErr2), sat(mFirst, 15));
   endtask

   // Drive one cycle of inputs, clock it, update the model and compare
   task automatic applyStimulus(input bit iRst, input bit iStart, input bit iStop,
                                input bit iS, input bit iR, input bit iQ);
      rst = iRst; start = iStart; stop = iStop; sIn = iS; rIn = iR; qIn = iQ;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   // One cycle where Q comes from a correctly behaving flip-flop
   task automatic ffCycle(input bit iStart, input bit iStop, input bit iS, input bit iR);
      applyStimulus(1'b1, iStart, iStop, iS, iR, ffQ);
      ffQ = ffNext(ffQ, iS, iR);
   endtask

   initial begin
      bit [1:0] pat;
      bit rS, rR, rStart, rStop, rRst, flip;

      tbl[0] = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 1};
      tbl[3] = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 2};
      tbl[4] = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 3};
      tbl[5] = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 4};
      tbl[6] = '{0, 1, 0, 0, 0,  0, 1, 1, 1, 5};
      tbl[7] = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 5};

      // reset with start held: start must be ignored
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_cnt",  int'(errCnt), 0);

      // golden run: correct flip-flop from Q=0, 10 cycles each of 00,01,10,00
      ffQ = 1'b0;
      ffCycle(1'b1, 1'b0, 1'b0, 1'b0);
      ffCycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         case (i / 10)
            0:       pat = 2'b00;
            1:       pat = 2'b01;
            2:       pat = 2'b10;
            default: pat = 2'b00;
         endcase
         ffCycle(1'b0, 1'b0, pat[1], pat[0]);
      end
      ffCycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("gold_pass", int'(pass), 1);
      chk("gold_err",  int'(errCnt), 0);
      chk("gold_ill",  int'(illCnt), 0);
      chk("gold_cyc",  int'(cycCnt), 41);

      // stuck-at-0 Q with S held: table of per-cycle expectations
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, tbl[i].start, tbl[i].stop, tbl[i].s, tbl[i].r, tbl[i].q);
         chk("tbl_busy",  int'(busy),     int'(tbl[i].eBusy));
         chk("tbl_done",  int'(done),     int'(tbl[i].eDone));
         chk("tbl_fail",  int'(fail),     int'(tbl[i].eFail));
         chk("tbl_pulse", int'(errPulse), int'(tbl[i].ePulse));
         chk("tbl_err",   int'(errCnt),   tbl[i].eErr);
         if (errPulse) pulses++;
      end
      chk("stuck_first",  int'(firstErr), 0);
      chk("stuck_pulses", pulses, 5);

      // illegal S=R=1 for three cycles, then compares resume after a decisive SET
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ill_cnt",     int'(illCnt), 3);
      chk("ill_err",     int'(errCnt), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ill_no_cmp",  int'(errCnt), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_resume",  int'(errCnt), 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("ill_fail",    int'(fail), 1);

      // saturation: twelve mismatches against the 3-bit counter
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("sat_narrow", int'(errCnt2), 7);
      chk("sat_wide",   int'(errCnt), 12);

      // reset in the middle of a run, then a clean run
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_err",  int'(errCnt), 0);
      chk("mid_cyc",  int'(cycCnt), 0);
      ffQ = 1'b0;
      ffCycle(1'b1, 1'b0, 1'b0, 1'b0);
      ffCycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ffCycle(1'b0, 1'b0, i[0], i[1] & ~i[0]);
      ffCycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("clean_pass", int'(pass), 1);
      // start and stop together in DONE: start wins and the verdict clears
      ffCycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rearm_busy", int'(busy), 1);
      chk("rearm_pass", int'(pass), 0);
      ffCycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rearm_cyc",  int'(cycCnt), 0);

      // randomized traffic with occasional Q faults, start/stop and resets
      for (int i = 0; i < 3000; i++) begin
         rS     = bit'($urandom_range(1, 0));
         rR     = bit'($urandom_range(1, 0));
         rStart = ($urandom_range(39, 0) == 0);
         rStop  = ($urandom_range(59, 0) == 0);
         rRst   = ($urandom_range(499, 0) != 0);
         flip   = ($urandom_range(9, 0) == 0);
         applyStimulus(rRst, rStart, rStop, rS, rR, ffQ ^ flip);
         ffQ = ffNext(ffQ, rS, rR);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
